fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Multi-operand forwarding and load-use interlock for the 5-stage core. Tracks in-flight destination
//  registers of the EX/MEM/WB stages internally, selects the newest value for every ID-stage operand,
//  and stalls ID one cycle when an operand depends on a load still in EX. Sits between decode and EX.
// PARAMETERS
//  NUM_OPR  2   number of source operands resolved per cycle
//  DATA_W   32  operand/result width
//  REG_AW   5   register address width; address 0 is hard-wired zero
//  CNT_W    16  width of saturating stall performance counter
// PORTS
//  clk           in   1                 core clock
//  rst_n         in   1                 asynchronous, active-low reset
//  id_valid      in   1                 ID holds a valid instruction this cycle
//  id_dst_addr   in   REG_AW            ID destination register (0 = no write)
//  id_is_load    in   1                 ID result comes from memory (not available until end of MEM)
//  id_opr_addr   in   NUM_OPR*REG_AW    operand k at [k*REG_AW +: REG_AW]
//  id_opr_data   in   NUM_OPR*DATA_W    regfile read data, operand k at [k*DATA_W +: DATA_W]
//  ex_alu_result in   DATA_W            ALU result of instruction now in EX
//  mem_result    in   DATA_W            final result of instruction now in MEM (ALU or load data)
//  wb_data       in   DATA_W            data being written to regfile by WB this cycle
//  pipe_hold     in   1                 external freeze (memory busy): no stage advances
//  flush         in   1                 squash instruction in ID (branch/exception)
//  fwd_data      out  NUM_OPR*DATA_W    resolved operand values
//  fwd_src       out  NUM_OPR*2         per-operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
//  hazard_stall  out  1                 ID must hold; bubble inserted into EX
//  stall_cnt     out  CNT_W             cycles with hazard_stall=1 and pipe_hold=0, saturating
// BEHAVIOUR
//  - State: per stage S in {EX,MEM,WB}: S_v, S_dst[REG_AW-1:0]; EX and MEM also S_ld.
//  - Reset (async, rst_n=0): all S_v=0, S_dst=0, S_ld=0, stall_cnt=0. Consequently fwd_data=id_opr_data,
//    fwd_src=0, hazard_stall=0 immediately.
//  - Advance on rising clk when pipe_hold=0: WB<=MEM; MEM<=EX; EX<=ID if id_valid & !hazard_stall
//    & !flush & id_dst_addr!=0, else bubble (EX_v=0). pipe_hold=1: all state held, flush ignored.
//  - Stage "hits" operand k iff S_v & S_dst==opr_addr_k & opr_addr_k!=0.
//  - Forward select per operand, combinational, zero latency, priority youngest first:
//    EX hit & !EX_ld -> ex_alu_result, src 1; EX hit & EX_ld -> src 1 reported, data=id_opr_data,
//    raises stall; else MEM hit -> mem_result, src 2; else WB hit -> wb_data, src 3; else regfile, src 0.
//  - opr_addr_k==0: always id_opr_data (expected 0), src 0, never stalls.
//  - hazard_stall = id_valid & OR over k of (EX hit & EX_ld). Independent of pipe_hold and flush.
//  - Load-use costs exactly 1 stall cycle: after bubble the load is in MEM and forwards via mem_result.
//  - Two operands same address: both resolved identically. Same dst in EX and MEM: EX wins.
//  - stall_cnt increments when hazard_stall & !pipe_hold; holds at 2^CNT_W-1; cleared only by reset.
//  - Reset asserted mid-stall: stall drops in same cycle (async); pending dst tracking lost by design.
// TESTING
//  1 add r3 in EX, ID reads r3 on opr0 -> fwd_data0=ex_alu_result (0x1234), src0=1, stall=0.
//  2 lw r5 in EX, ID reads r5 on opr1 -> stall=1 one cycle, EX bubble; next cycle src1=2,
//    fwd_data1=mem_result (0xDEADBEEF), stall=0; stall_cnt 0->1.
//  3 r7 written by both EX (0xA) and MEM (0xB) stages, ID reads r7 -> 0xA, src=1; with EX bubble -> 0xB.
//  4 ID reads r0 while EX writes r0 -> id_opr_data returned, src 0, stall 0; EX_v stays 0.
//  5 load-use with pipe_hold=1 for 3 cycles -> stall stays 1, stall_cnt unchanged, state frozen;
//    release -> bubble inserted, stall_cnt +1.
//  6 rst_n low during load-use stall -> stall=0, fwd_src=0, stall_cnt=0 without waiting for clk.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock between decode and EX.
// Tracks EX/MEM/WB destinations and picks the youngest producer per operand.
module fwd_hazard_unit #(
  parameter int NUM_OPR = 2,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_is_load,
  input  logic [NUM_OPR*REG_AW-1:0] id_opr_addr,
  input  logic [NUM_OPR*DATA_W-1:0] id_opr_data,
  input  logic [DATA_W-1:0]         ex_alu_result,
  input  logic [DATA_W-1:0]         mem_result,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      pipe_hold,
  input  logic                      flush,
  output logic [NUM_OPR*DATA_W-1:0] fwd_data,
  output logic [NUM_OPR*2-1:0]      fwd_src,
  output logic                      hazard_stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic              ex_v_q, ex_v_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              ex_ld_q, ex_ld_d;
  logic              mem_v_q, mem_v_d;
  logic [REG_AW-1:0] mem_dst_q, mem_dst_d;
  logic              wb_v_q, wb_v_d;
  logic [REG_AW-1:0] wb_dst_q, wb_dst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [NUM_OPR-1:0] ex_hit, mem_hit, wb_hit, ld_hit;

  always_comb begin
    fwd_data = id_opr_data;
    fwd_src  = '0;
    ex_hit   = '0;
    mem_hit  = '0;
    wb_hit   = '0;
    ld_hit   = '0;
    for (int k = 0; k < NUM_OPR; k++) begin
      if (id_opr_addr[k*REG_AW +: REG_AW] != '0) begin
        ex_hit[k]  = ex_v_q  &&
                     (ex_dst_q  == id_opr_addr[k*REG_AW +: REG_AW]);
        mem_hit[k] = mem_v_q &&
                     (mem_dst_q == id_opr_addr[k*REG_AW +: REG_AW]);
        wb_hit[k]  = wb_v_q  &&
                     (wb_dst_q  == id_opr_addr[k*REG_AW +: REG_AW]);
      end
      if (ex_hit[k]) begin
        fwd_src[k*2 +: 2] = 2'd1;
        // load data does not exist yet; ID waits one cycle
        if (ex_ld_q) ld_hit[k] = 1'b1;
        else fwd_data[k*DATA_W +: DATA_W] = ex_alu_result;
      end else if (mem_hit[k]) begin
        fwd_src[k*2 +: 2] = 2'd2;
        fwd_data[k*DATA_W +: DATA_W] = mem_result;
      end else if (wb_hit[k]) begin
        fwd_src[k*2 +: 2] = 2'd3;
        fwd_data[k*DATA_W +: DATA_W] = wb_data;
      end
    end
    hazard_stall = id_valid & (|ld_hit);
  end

  always_comb begin
    ex_v_d      = ex_v_q;
    ex_dst_d    = ex_dst_q;
    ex_ld_d     = ex_ld_q;
    mem_v_d     = mem_v_q;
    mem_dst_d   = mem_dst_q;
    wb_v_d      = wb_v_q;
    wb_dst_d    = wb_dst_q;
    stall_cnt_d = stall_cnt_q;
    if (!pipe_hold) begin
      wb_v_d    = mem_v_q;
      wb_dst_d  = mem_dst_q;
      mem_v_d   = ex_v_q;
      mem_dst_d = ex_dst_q;
      if (id_valid && !hazard_stall && !flush &&
          (id_dst_addr != '0)) begin
        ex_v_d   = 1'b1;
        ex_dst_d = id_dst_addr;
        ex_ld_d  = id_is_load;
      end else begin
        ex_v_d   = 1'b0;
        ex_dst_d = '0;
        ex_ld_d  = 1'b0;
      end
      if (hazard_stall && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_dst_q    <= '0;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_dst_q   <= '0;
      wb_v_q      <= 1'b0;
      wb_dst_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_dst_q    <= ex_dst_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_dst_q   <= mem_dst_d;
      wb_v_q      <= wb_v_d;
      wb_dst_q    <= wb_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority,
// load-use interlock, hold/flush behaviour and async reset.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_dst_addr;
  logic        id_is_load;
  logic [9:0]  id_opr_addr;
  logic [63:0] id_opr_data;
  logic [31:0] ex_alu_result;
  logic [31:0] mem_result;
  logic [31:0] wb_data;
  logic        pipe_hold;
  logic        flush;
  logic [63:0] fwd_data;
  logic [3:0]  fwd_src;
  logic        hazard_stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int bad    = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_dst_addr(id_dst_addr),
    .id_is_load(id_is_load), .id_opr_addr(id_opr_addr),
    .id_opr_data(id_opr_data), .ex_alu_result(ex_alu_result),
    .mem_result(mem_result), .wb_data(wb_data),
    .pipe_hold(pipe_hold), .flush(flush),
    .fwd_data(fwd_data), .fwd_src(fwd_src),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] dst,
                        input logic ld,
                        input logic [4:0] a0, input logic [4:0] a1);
    id_valid    = v;
    id_dst_addr = dst;
    id_is_load  = ld;
    id_opr_addr = {a1, a0};
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    pipe_hold     = 1'b0;
    flush         = 1'b0;
    id_opr_data   = 64'h2222_2222_1111_1111;
    ex_alu_result = 32'h0000_1234;
    mem_result    = 32'h0000_0055;
    wb_data       = 32'h0000_0066;
    id_set(1'b1, 5'd0, 1'b0, 5'd3, 5'd4);
    #12;
    chk("rst_src", 64'(fwd_src), 64'h0);
    chk("rst_data", fwd_data, 64'h2222_2222_1111_1111);
    chk("rst_stall", 64'(hazard_stall), 64'h0);
    chk("rst_cnt", 64'(stall_cnt), 64'h0);
    rst_n = 1'b1;

    // ALU producer moving through EX, MEM, WB
    id_set(1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd3, 5'd4);
    chk("t1_ex_data", 64'(fwd_data[31:0]), 64'h1234);
    chk("t1_ex_src", 64'(fwd_src), 64'h1);
    chk("t1_opr1_rf", 64'(fwd_data[63:32]), 64'h2222_2222);
    chk("t1_stall", 64'(hazard_stall), 64'h0);
    tick();
    chk("t1_mem_data", 64'(fwd_data[31:0]), 64'h55);
    chk("t1_mem_src", 64'(fwd_src), 64'h2);
    tick();
    chk("t1_wb_data", 64'(fwd_data[31:0]), 64'h66);
    chk("t1_wb_src", 64'(fwd_src), 64'h3);
    tick();
    chk("t1_gone_src", 64'(fwd_src), 64'h0);

    // load-use on operand 1
    mem_result  = 32'hDEAD_BEEF;
    id_opr_data = 64'h0000_0077_0000_0000;
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
    tick();
    id_set(1'b1, 5'd6, 1'b0, 5'd0, 5'd5);
    chk("t2_stall", 64'(hazard_stall), 64'h1);
    chk("t2_src_ld", 64'(fwd_src), 64'h4);
    chk("t2_data_ld", 64'(fwd_data[63:32]), 64'h77);
    chk("t2_cnt0", 64'(stall_cnt), 64'h0);
    tick();
    chk("t2_stall_off", 64'(hazard_stall), 64'h0);
    chk("t2_src_mem", 64'(fwd_src), 64'h8);
    chk("t2_data_mem", 64'(fwd_data[63:32]), 64'hDEAD_BEEF);
    chk("t2_cnt1", 64'(stall_cnt), 64'h1);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd6, 5'd5);
    chk("t2_after_src", 64'(fwd_src), 64'hD);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    tick();

    // same dst in EX and MEM; both operands alike
    ex_alu_result = 32'hA;
    mem_result    = 32'hB;
    id_set(1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd7, 5'd7);
    chk("t3_ex_wins", fwd_data, 64'h0000_000A_0000_000A);
    chk("t3_src", 64'(fwd_src), 64'h5);
    tick();
    chk("t3_mem", fwd_data, 64'h0000_000B_0000_000B);
    chk("t3_src_mem", 64'(fwd_src), 64'hA);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    tick();

    // r0 never tracked; flushed instruction never tracked
    id_opr_data = 64'h0;
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    tick();
    chk("t4_r0_src", 64'(fwd_src), 64'h0);
    chk("t4_r0_stall", 64'(hazard_stall), 64'h0);
    chk("t4_r0_data", fwd_data, 64'h0);
    id_set(1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_set(1'b1, 5'd0, 1'b0, 5'd9, 5'd0);
    chk("t4_flush_src", 64'(fwd_src), 64'h0);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    tick();

    // load-use frozen by pipe_hold
    mem_result = 32'hCAFE_0001;
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
    tick();
    id_set(1'b1, 5'd8, 1'b0, 5'd5, 5'd0);
    pipe_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_stall", 64'(hazard_stall), 64'h1);
      chk("t5_hold_cnt", 64'(stall_cnt), 64'h1);
    end
    pipe_hold = 1'b0;
    tick();
    chk("t5_rel_cnt", 64'(stall_cnt), 64'h2);
    chk("t5_rel_stall", 64'(hazard_stall), 64'h0);
    chk("t5_rel_src", 64'(fwd_src), 64'h2);
    chk("t5_rel_data", 64'(fwd_data[31:0]), 64'hCAFE_0001);

    // async reset during a load-use stall
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 5'd0);
    tick();
    id_opr_data = 64'h3333_3333_4444_4444;
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 5'd5);
    chk("t6_pre_stall", 64'(hazard_stall), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_stall", 64'(hazard_stall), 64'h0);
    chk("t6_src", 64'(fwd_src), 64'h0);
    chk("t6_cnt", 64'(stall_cnt), 64'h0);
    chk("t6_data", fwd_data, 64'h3333_3333_4444_4444);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
